// File: rtl/nic_pkg.sv
// Shared constants for the NIC: CPU register map, status field layout and
// overflow-counter width.
package nic_pkg;

   localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

   // Status bit positions, counted from the numeric LSB of the status word
   localparam int STAT_FLAG_LSB = 0;
   localparam int STAT_CNT_LSB  = 1;
   localparam int STAT_OVF_LSB  = 8;

   localparam int OVF_W = 8;

endpackage

// File: rtl/nic_fifo_buf.sv
// Count-tracked packet FIFO with synchronous push/pop and a registered head;
// pushes while full and pops while empty are ignored.
module nic_fifo_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign full       = (count == CNT_FULL);
   assign empty      = (count == '0);
   assign push_ok    = push && !full;
   assign pop_ok     = pop && !empty;
   assign rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nxt;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Bypass the incoming word when it becomes the new head this cycle
   always_ff @(posedge clk) begin
      head <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
   end

endmodule

// File: rtl/nic_fifo.sv
// NIC between a processing element and its mesh router port, with DEPTH-entry
// FIFOs each way. Optional drop/underflow counter: NIC_OVERFLOW_CNT_EN.
module nic_fifo
   import nic_pkg::*;
#(
   parameter int   PACKET_WIDTH  = 64,
   parameter int   DEPTH         = 4,
   parameter logic SEND_POLARITY = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              addr,
   input  logic [0:PACKET_WIDTH-1] d_in,
   output logic [0:PACKET_WIDTH-1] d_out,
   input  logic                    nicEn,
   input  logic                    nicEnWR,
   input  logic                    net_si,
   output logic                    net_ri,
   input  logic [0:PACKET_WIDTH-1] net_di,
   output logic                    net_so,
   input  logic                    net_ro,
   output logic [0:PACKET_WIDTH-1] net_do,
   input  logic                    net_polarity
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PACKET_WIDTH-1:0] in_head;
   logic [PACKET_WIDTH-1:0] out_head;
   logic [CNT_W-1:0]        in_count;
   logic [CNT_W-1:0]        out_count;
   logic                    in_full, in_empty, out_full, out_empty;
   logic                    cpu_rd, cpu_wr, in_pop, out_push, send;
   logic [PACKET_WIDTH-1:0] d_out_nxt;
   logic [OVF_W-1:0]        ovf_cnt;

   assign cpu_rd   = nicEn && !nicEnWR;
   assign cpu_wr   = nicEn && nicEnWR;
   assign in_pop   = cpu_rd && (addr == ADDR_IN_DATA);
   assign out_push = cpu_wr && (addr == ADDR_OUT_DATA);
   assign net_ri   = !in_full;
   // Gating on net_so spaces sends at least two cycles apart
   assign send     = !out_empty && net_ro && (net_polarity == SEND_POLARITY) && !net_so;

   nic_fifo_buf #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_in_buf (
      .clk   (clk),
      .reset (reset),
      .push  (net_si),
      .pop   (in_pop),
      .din   (net_di),
      .head  (in_head),
      .count (in_count),
      .full  (in_full),
      .empty (in_empty)
   );

   nic_fifo_buf #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_out_buf (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .pop   (send),
      .din   (d_in),
      .head  (out_head),
      .count (out_count),
      .full  (out_full),
      .empty (out_empty)
   );

   function automatic logic [PACKET_WIDTH-1:0] pack_status(input logic             flag,
                                                           input logic [CNT_W-1:0] cnt,
                                                           input logic [OVF_W-1:0] ovf);
      logic [PACKET_WIDTH-1:0] s;
      s = '0;
      s[STAT_FLAG_LSB]           = flag;
      s[STAT_CNT_LSB +: CNT_W]   = cnt;
      s[STAT_OVF_LSB +: OVF_W]   = ovf;
      return s;
   endfunction

`ifdef NIC_OVERFLOW_CNT_EN
   logic ovf_evt;
   logic ovf_clr_pend;

   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   assign ovf_evt = (in_pop && in_empty) || (out_push && out_full);

   // A status read captures the count first; the clear lands one edge later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_cnt      <= '0;
         ovf_clr_pend <= 1'b0;
      end else begin
         ovf_clr_pend <= cpu_rd && addr[0];
         if (ovf_clr_pend)
            ovf_cnt <= ovf_evt ? OVF_W'(1) : '0;
         else if (ovf_evt)
            ovf_cnt <= sat_inc(ovf_cnt);
      end
   end
`else
   assign ovf_cnt = '0;
`endif

   always_comb begin
      d_out_nxt = d_out;
      if (cpu_rd) begin
         case (addr)
            ADDR_IN_DATA:  d_out_nxt = in_empty ? '0 : in_head;
            ADDR_IN_STAT:  d_out_nxt = pack_status(!in_empty, in_count, ovf_cnt);
            ADDR_OUT_STAT: d_out_nxt = pack_status(out_full, out_count, ovf_cnt);
            default:       d_out_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) d_out <= '0;
      else       d_out <= d_out_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         net_so <= 1'b0;
         net_do <= '0;
      end else begin
         net_so <= send;
         if (send) net_do <= out_head;
      end
   end

endmodule

// File: tb/tb_nic_fifo.sv
// Scoreboard bench for nic_fifo: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_nic_fifo;

   localparam int   W     = 64;
   localparam int   DEPTH = 4;
   localparam logic SP    = 1'b1;
`ifdef NIC_OVERFLOW_CNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   addr;
   logic [0:W-1] d_in, d_out, net_di, net_do;
   logic         nicEn, nicEnWR, net_si, net_ri, net_so, net_ro, net_polarity;

   always #5 clk = ~clk;

   nic_fifo #(.PACKET_WIDTH(W), .DEPTH(DEPTH), .SEND_POLARITY(SP)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicEnWR      (nicEnWR),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity)
   );

   typedef struct {
      int           due;
      logic [W-1:0] val;
   } exp_t;

   logic [W-1:0] m_in[$];
   logic [W-1:0] m_out[$];
   int           m_ovf;
   bit           m_clr;
   bit           m_so;
   exp_t         rd_q[$];
   string        rd_name_q[$];
   exp_t         inj_q[$];
   int           cyc;
   int           checks;
   int           failures;
   bit           started;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] stat_word(input bit flag, input int cnt);
      logic [W-1:0] v;
      v = W'(cnt) * 2 + (flag ? 1 : 0);
      if (OVF_EN) v += W'(m_ovf) * 256;
      return v;
   endfunction

   // Reference model: applies one clock edge using the spec's rules on queues
   task automatic model_edge();
      bit   in_full_pre  = (m_in.size() == DEPTH);
      bit   out_full_pre = (m_out.size() == DEPTH);
      bit   rd           = nicEn && !nicEnWR;
      bit   wr           = nicEn && nicEnWR;
      bit   inc          = 1'b0;
      bit   stat_rd      = 1'b0;
      bit   snd;
      exp_t e;
      cyc++;
      if (rd) begin
         e.due = cyc;
         case (addr)
            2'd0: begin
               if (m_in.size() > 0) e.val = m_in.pop_front();
               else begin e.val = '0; inc = 1'b1; end
               rd_name_q.push_back("rd_in_data");
            end
            2'd1: begin
               e.val = stat_word(m_in.size() > 0, m_in.size());
               stat_rd = 1'b1;
               rd_name_q.push_back("rd_in_stat");
            end
            2'd2: begin
               e.val = '0;
               rd_name_q.push_back("rd_out_data");
            end
            default: begin
               e.val = stat_word(out_full_pre, m_out.size());
               stat_rd = 1'b1;
               rd_name_q.push_back("rd_out_stat");
            end
         endcase
         rd_q.push_back(e);
      end
      if (net_si && !in_full_pre) m_in.push_back(net_di);
      snd = (m_out.size() > 0) && net_ro && (net_polarity == SP) && !m_so;
      if (snd) begin
         e.due = cyc;
         e.val = m_out.pop_front();
         inj_q.push_back(e);
      end
      m_so = snd;
      if (wr && addr == 2'd2) begin
         if (!out_full_pre) m_out.push_back(d_in);
         else inc = 1'b1;
      end
      if (OVF_EN) begin
         if (m_clr) m_ovf = inc ? 1 : 0;
         else if (inc && m_ovf < 255) m_ovf++;
         m_clr = stat_rd;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit en, input bit wr, input logic [1:0] a, input logic [W-1:0] din,
                        input bit si, input logic [W-1:0] di, input bit ro, input bit pol);
      nicEn = en; nicEnWR = wr; addr = a; d_in = din;
      net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
   endtask

   task automatic model_clear();
      m_in.delete(); m_out.delete(); rd_q.delete(); rd_name_q.delete(); inj_q.delete();
      m_ovf = 0; m_clr = 1'b0; m_so = 1'b0;
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard
   int    last_so = -10;
   bit    prev_pol;
   exp_t  mon_e;
   string mon_n;
   always @(negedge clk) begin
      if (reset || !started) begin
         last_so = -10;
      end else begin
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            mon_e = rd_q.pop_front();
            mon_n = rd_name_q.pop_front();
            check(mon_n, d_out, mon_e.val);
         end
         check("net_ri", W'(net_ri), W'(m_in.size() < DEPTH));
         if (inj_q.size() > 0 && inj_q[0].due == cyc) begin
            mon_e = inj_q.pop_front();
            check("net_so", W'(net_so), 1);
            check("net_do", net_do, mon_e.val);
         end else begin
            check("net_so_idle", W'(net_so), 0);
         end
         if (net_so) begin
            check("so_phase", W'(prev_pol), W'(SP));
            check("so_gap", W'(cyc - last_so >= 2), 1);
            last_so = cyc;
         end
      end
      prev_pol = net_polarity;
   end

   logic [W-1:0] tmp;
   bit           p;

   initial begin
      checks = 0; failures = 0; cyc = 0; started = 1'b0;
      model_clear();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      started = 1'b1;
      check("rst_d_out", d_out, 0);
      check("rst_net_so", W'(net_so), 0);
      check("rst_net_do", net_do, 0);
      check("rst_net_ri", W'(net_ri), 1);

      drive(1, 0, 2'd1, 0, 0, 0, 0, 0); step();

      // Fill the input FIFO, then one push that must be ignored
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, 1, W'(i), 0, 0); step();
      end
      check("ri_when_full", W'(net_ri), 0);
      drive(0, 0, 0, 0, 1, 64'h99, 0, 0); step();
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive(1, 0, 2'd0, 0, 0, 0, 0, 0); step();
      end
      drive(1, 0, 2'd1, 0, 0, 0, 0, 0); step();
      tmp = d_out;
      check("ovf_after_underflow", W'(tmp[15:8]), OVF_EN ? 1 : 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();

      // Injection with polarity toggling every cycle
      p = 1'b0;
      drive(1, 1, 2'd2, 64'hA, 0, 0, 1, p); step(); p = ~p;
      drive(1, 1, 2'd2, 64'hB, 0, 0, 1, p); step(); p = ~p;
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, p); step(); p = ~p;
      end

      // Output FIFO full, then a dropped write
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 1, 2'd2, W'(16 + i), 0, 0, 0, 0); step();
      end
      drive(1, 1, 2'd2, 64'hF, 0, 0, 0, 0); step();
      drive(1, 0, 2'd3, 0, 0, 0, 0, 0); step();
      tmp = d_out;
      check("out_stat_full", W'(tmp[7:0]), 9);
      for (int i = 0; i < 14; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, p); step(); p = ~p;
      end

      // Simultaneous router push and CPU pop with two packets queued
      drive(0, 0, 0, 0, 1, 64'h21, 0, 0); step();
      drive(0, 0, 0, 0, 1, 64'h22, 0, 0); step();
      drive(1, 0, 2'd0, 0, 1, 64'h23, 0, 0); step();
      drive(1, 0, 2'd1, 0, 0, 0, 0, 0); step();
      tmp = d_out;
      check("in_stat_pushpop", W'(tmp[7:0]), 5);
      drive(1, 0, 2'd0, 0, 0, 0, 0, 0); step();
      drive(1, 0, 2'd0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step();

      // Reset while a send is on the wire and packets are queued
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 2'd2, W'(48 + i), 1, W'(64 + i), 0, 0); step();
      end
      drive(0, 0, 0, 0, 0, 0, 1, SP); step();
      check("so_before_rst", W'(net_so), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b1;
      #1;
      check("so_async_rst", W'(net_so), 0);
      check("ri_async_rst", W'(net_ri), 1);
      model_clear();
      @(negedge clk);
      #1 reset = 1'b0;
      drive(1, 0, 2'd1, 0, 0, 0, 0, 0); step();
      check("in_stat_after_rst", d_out, 0);
      drive(1, 0, 2'd3, 0, 0, 0, 0, 0); step();
      check("out_stat_after_rst", d_out, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               {$urandom(), $urandom()}, bit'($urandom_range(0, 1)), {$urandom(), $urandom()},
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      check("rd_q_drained", W'(rd_q.size()), 0);
      check("inj_q_drained", W'(inj_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
